// File: rtl/detect_ctrl.sv
// rtl/detect_ctrl.sv - phase sequencer for the cypher detector datapath
// Optional idle-timeout exit from SCAN is compiled in with `define DETECT_TIMEOUT_EN.
module detect_ctrl #(
  parameter int KEY_LEN = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             read,
  input  logic             stop,
  input  logic             sym_valid,
  input  logic             match,
  output logic             load_en,
  output logic             shift_en,
  output logic             sl_op,
  output logic             sl_res,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             found,
  output logic             timeout,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SCAN = 3'd2,
    S_HOLD = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic [7:0] KEY_LAST = 8'(KEY_LEN - 1);

  state_e           state_q, state_d;
  logic [7:0]       key_idx_q, key_idx_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic             sl_op_q, sl_op_d;
  logic             sl_res_q, sl_res_d;
  logic             found_q, found_d;
  logic             timeout_q, timeout_d;
  logic             key_last;
  logic             scan_run;
  logic             count_hit;
  logic             to_hit;

  assign load_en   = (state_q == S_LOAD) && sym_valid && !stop;
  assign shift_en  = (state_q == S_SCAN) && sym_valid && !stop;
  // SCAN cycles that neither stop nor pause; only these count matches or age the idle counter
  assign scan_run  = (state_q == S_SCAN) && !stop && read;
  assign key_last  = (key_idx_q == KEY_LAST);
  assign count_hit = scan_run && sym_valid && match;

`ifdef DETECT_TIMEOUT_EN
  localparam logic [15:0] TO_VAL = 16'(TIMEOUT);

  logic [15:0] idle_q, idle_d;

  assign to_hit = scan_run && (idle_q == TO_VAL);

  always_comb begin
    idle_d = idle_q;
    if (load_en && key_last) begin
      idle_d = '0;
    end else if (scan_run) begin
      idle_d = sym_valid ? 16'd0 : idle_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      key_idx_q <= '0;
      hit_cnt_q <= '0;
      sl_op_q   <= 1'b0;
      sl_res_q  <= 1'b0;
      found_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_idx_q <= key_idx_d;
      hit_cnt_q <= hit_cnt_d;
      sl_op_q   <= sl_op_d;
      sl_res_q  <= sl_res_d;
      found_q   <= found_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (read && !stop) state_d = S_LOAD;
      S_LOAD: begin
        if (stop)                     state_d = S_IDLE;
        else if (load_en && key_last) state_d = S_SCAN;
      end
      S_SCAN: begin
        if (stop)        state_d = S_DONE;
        else if (!read)  state_d = S_HOLD;
        else if (to_hit) state_d = S_DONE;
      end
      S_HOLD: begin
        if (stop)      state_d = S_DONE;
        else if (read) state_d = S_SCAN;
      end
      S_DONE:  if (!read && !stop) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    key_idx_d = key_idx_q;
    hit_cnt_d = hit_cnt_q;
    if ((state_q == S_IDLE) && (state_d == S_LOAD)) begin
      key_idx_d = '0;
      hit_cnt_d = '0;
    end else if (load_en) begin
      key_idx_d = key_idx_q + 8'd1;
    end
    if (count_hit && (hit_cnt_q != {CNT_W{1'b1}})) begin
      hit_cnt_d = hit_cnt_q + CNT_W'(1);
    end
    found_d  = count_hit;
    // Select lines follow the next state so they change on the same edge as state
    sl_op_d  = (state_d == S_SCAN) || (state_d == S_HOLD);
    sl_res_d = (state_d == S_DONE);
    if (state_d != S_DONE) begin
      timeout_d = 1'b0;
    end else if (state_q == S_DONE) begin
      timeout_d = timeout_q;
    end else begin
      timeout_d = to_hit;
    end
  end

  assign sl_op   = sl_op_q;
  assign sl_res  = sl_res_q;
  assign hit_cnt = hit_cnt_q;
  assign found   = found_q;
  assign timeout = timeout_q;
  assign state   = state_q;

endmodule

// File: doc/detect_ctrl.md
# detect_ctrl

Sequencing controller for the cypher detector datapath. It takes the operator-level `read`/`stop` commands and runs the datapath through four phases: key load, stream scan, pause and result hold. While doing so it drives the datapath select lines (`sl_op`, `sl_res`), the key-load and shift enables, and a saturating match counter. It sits between the command inputs and the compare/shift-register datapath, and replaces ad-hoc select logic with an explicit phase FSM.

## Interface
- `KEY_LEN`, 4: number of valid key symbols loaded before scanning; legal range 1..255.
- `CNT_W`, 8: width of the match counter `hit_cnt`.
- `TIMEOUT`, 255: idle SCAN cycles with no `sym_valid` before forced DONE; legal range 1..65535.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `read`  in  1  run request; level-sensitive.
- `stop`  in  1  terminate request; level-sensitive; priority over `read` and `sym_valid`.
- `sym_valid`  in  1  datapath presents a symbol this cycle.
- `match`  in  1  datapath comparator hit; qualified by `sym_valid`.
- `load_en`  out  1  key register load strobe, combinational: LOAD & `sym_valid` & !`stop`.
- `shift_en`  out  1  scan shift strobe, combinational: SCAN & `sym_valid` & !`stop`.
- `sl_op`  out  1  registered; 1 in SCAN and HOLD.
- `sl_res`  out  1  registered; 1 in DONE.
- `hit_cnt`  out  CNT_W  registered match count.
- `found`  out  1  registered one-cycle pulse per counted match.
- `timeout`  out  1  registered; 1 in DONE when DONE was entered by timeout.
- `state`  out  3  current state: IDLE=0, LOAD=1, SCAN=2, HOLD=3, DONE=4.

## Operation
- Reset (async, any time, including mid-operation): state=IDLE. All registered outputs, `key_idx` and the idle counter clear to 0. Combinational enables are therefore 0.
- **IDLE**
  - `read`=1 and `stop`=0 -> LOAD; `key_idx` and `hit_cnt` clear.
  - Otherwise stay.
- **LOAD**
  - `stop`=1 -> IDLE.
  - Each `load_en` cycle increments `key_idx`.
  - The `load_en` cycle that makes `key_idx` reach KEY_LEN -> SCAN, and the idle counter clears.
  - `read` deassertion is ignored in LOAD.
- **SCAN**
  - `stop`=1 -> DONE, `timeout`=0.
  - Else `read`=0 -> HOLD.
  - Else, when `sym_valid` & `match`: `hit_cnt` increments, saturating at 2^CNT_W-1, and `found`=1 next cycle. `found` still pulses when `hit_cnt` is saturated.
  - `sym_valid` clears the idle counter. A cycle without it increments the counter.
  - Idle counter reaching TIMEOUT -> DONE with `timeout`=1.
- **HOLD**
  - `stop`=1 -> DONE, `timeout`=0.
  - `read`=1 -> SCAN.
  - `sym_valid` is ignored; no enables; the idle counter is frozen.
- **DONE**
  - `sl_res`=1; `hit_cnt` and `timeout` are held.
  - `read`=0 and `stop`=0 -> IDLE; `timeout` clears on exit.
- Simultaneous events:
  - `stop` with `sym_valid`: the symbol is neither loaded nor counted.
  - `stop` with timeout expiry: `timeout`=0.
  - `read` and `stop` together in IDLE: stay in IDLE.

## Timing
- All state and registered outputs update on the rising edge of `clock`. They are visible in the cycle after the causing input is sampled.
- `load_en` and `shift_en` are same-cycle combinational, with no register stage.
- Match to `found`/`hit_cnt` update: 1 cycle.
- `read`=1 in IDLE to LOAD: 1 cycle. LOAD to SCAN occurs on the edge that samples the KEY_LEN-th valid symbol.
- Timeout: DONE is entered on the edge at which the idle count equals TIMEOUT. With continuous idle input, that is TIMEOUT+1 cycles after entering SCAN. `sl_res` goes to 1 on that same edge.

## Configuration
- `DETECT_TIMEOUT_EN` defined: the idle counter and timeout exit are compiled in, as described above.
- `DETECT_TIMEOUT_EN` undefined: no idle counter, and SCAN exits only via `stop` or `read`. `timeout` is tied to 0 and the TIMEOUT parameter is unused.

## Test plan
- **Reset and load:** assert `reset`, release, `read`=1, then 4 `sym_valid` cycles -> `load_en` high exactly 4 cycles; state goes 0->1->2, reaching SCAN after the 4th symbol; `sl_op`=1 one cycle later.
- **Match counting:** in SCAN, 6 `sym_valid` cycles with `match` on 3 of them -> `hit_cnt`=3 and 3 single-cycle `found` pulses. With CNT_W=2 and 5 matches -> `hit_cnt` saturates at 3.
- **Pause and stop:** in SCAN drop `read` -> HOLD (3), `sl_op` stays 1, and `sym_valid` is not counted. Reassert `read` -> SCAN. Assert `stop` with `sym_valid`&`match` -> DONE (4), `sl_res`=1, `hit_cnt` unchanged.
- **Timeout:** with `DETECT_TIMEOUT_EN` and TIMEOUT=5, no `sym_valid` in SCAN -> DONE with `timeout`=1 after 6 cycles. Without the macro, state stays 2 after 100 idle cycles.
- **Reset mid-operation:** `reset` pulse during LOAD with `key_idx`=2 -> immediate state=0 and all outputs 0. A new `read` then requires 4 fresh symbols.
- **Release from DONE:** drop `read` and `stop` in DONE -> IDLE next cycle with `sl_res`=0 and `timeout`=0. `hit_cnt` is held until the next LOAD entry.
